seq_frame_scheduler: RTL
========================

Name: seq_frame_scheduler

Overview:
Controller that shares one bit-serial sequence detector between two frame requesters. It arbitrates between requesters round-robin, then clears the detector and shifts the granted frame into it MSB-first, one bit per clock. It counts detector hits (det_z pulses) over the frame and returns the hit count and source ID through a valid/ready result port. It sits between the frame sources and the detector instance.

Parameters:
FRAME_W, 7, bits per frame, shifted MSB-first; must be at least 2
CNT_W, 3, hit-counter width; must hold FRAME_W; the counter saturates at all-ones

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
req0_valid  in  1  requester 0 has a frame
req0_frame  in  FRAME_W  requester 0 frame data
req0_ready  out  1  requester 0 frame accepted this cycle
req1_valid  in  1  requester 1 has a frame
req1_frame  in  FRAME_W  requester 1 frame data
req1_ready  out  1  requester 1 frame accepted this cycle
det_clr  out  1  one-cycle synchronous clear to the detector
det_en  out  1  det_bit is valid; detector advances this cycle
det_bit  out  1  current serial bit
det_z  in  1  detector hit, registered; refers to the bit from the previous cycle
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_count  out  CNT_W  hits counted over the frame
res_src  out  1  requester ID of the result (0/1)

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - All outputs are 0; the counter and frame register are 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-frame abandons the frame with no result.
  - Reset has no effect on requesters beyond deasserting ready.
- FSM states and transitions:
  - IDLE: if exactly one reqN_valid is set, grant it. If both are set, grant the one not equal to last_grant. reqN_ready=1 for the granted requester only, in the same cycle (combinational from valid and state). Latch frame and src, set last_grant=src, clear the counter, go to CLEAR. With no valid, stay in IDLE with ready=0.
  - CLEAR: det_clr=1 for one cycle, bit index=FRAME_W-1, go to SHIFT.
  - SHIFT: det_en=1 and det_bit=frame[index]. Decrement the index. When index==0 this cycle, go to DRAIN.
  - DRAIN: one cycle to capture the det_z from the final bit, then go to REPORT.
  - REPORT: res_valid=1, with res_count and res_src held stable. When res_valid and res_ready are both high, go to IDLE. No new grant is made in the same cycle.
- Hit counting:
  - en_d is det_en delayed by one cycle.
  - Increment the counter on (en_d and det_z); this covers the SHIFT cycles after the first and the DRAIN cycle.
  - Ignore det_z at all other times, including during CLEAR and REPORT.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- Timing, with acceptance at cycle T:
  - det_clr at T+1.
  - det_en at T+2 .. T+FRAME_W+1.
  - DRAIN at T+FRAME_W+2.
  - res_valid from T+FRAME_W+3. For the default FRAME_W=7 that is T+10.
- Throughput: one frame per FRAME_W+4 cycles minimum, when res_ready is held high.
- Requester inputs are sampled only at acceptance. Frame changes after acceptance have no effect.
- det_bit is 0 whenever det_en=0.

Decomposition:
- Shared package seq_sched_pkg holds:
  - the FSM state encoding (IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, REPORT=4; 3 bits);
  - FRAME_W and CNT_W defaults;
  - the source-ID constants SRC0=0, SRC1=1.
- One sub-module: rr_arb2.
  - Inputs: the two valids, last_grant, enable (IDLE).
  - Outputs: one-hot grant and grant_id.
  - Purely combinational.

Test Plan:
- Single request, requester 0: req0_frame=7'b1011001, det_z scripted high 1 cycle after the 2nd and 5th det_en. Required: req0_ready at T; det_bit sequence 1,0,1,1,0,0,1 at T+2..T+8; res_valid at T+10 with res_count=2, res_src=0.
- Simultaneous requests: both valid after reset. Required: requester 0 granted first; requester 1 granted on the next IDLE, with res_src=1 on the second result. Repeat with both held high: grants alternate 0,1,0,1.
- Backpressure: res_ready=0 for 5 cycles in REPORT. Required: res_valid, res_count and res_src stable; req0_ready and req1_ready stay 0; IDLE is entered the cycle after the handshake.
- Saturation: CNT_W=2, det_z high on every counted cycle. Required: res_count=3, with no wrap to 0.
- Stray det_z: det_z=1 during CLEAR and REPORT only. Required: res_count=0.
- Async reset mid-SHIFT: reset low at the 3rd bit. Required: det_en, det_clr and res_valid drop to 0 immediately; after release, the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the frame scheduler and its round-robin arbiter.
package seq_sched_pkg;

    localparam int FRAME_W_DEF = 7;
    localparam int CNT_W_DEF   = 3;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2
    import seq_sched_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = SRC0;
        if (enable_i) begin
            if (valid0_i && valid1_i) begin
                grant_id_o = ~last_grant_i;
            end else if (valid1_i) begin
                grant_id_o = SRC1;
            end else begin
                grant_id_o = SRC0;
            end
            if (valid0_i || valid1_i) begin
                grant_o = (grant_id_o == SRC1) ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: rtl/seq_frame_scheduler.sv
// Shares one bit-serial sequence detector between two requesters: arbitrate, clear,
// shift the frame MSB-first, count det_z hits and hand back count plus source ID.
module seq_frame_scheduler
    import seq_sched_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_frame,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_frame,
    output logic               req1_ready,
    output logic               det_clr,
    output logic               det_en,
    output logic               det_bit,
    input  logic               det_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_src
);

    localparam int IDX_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               src_q, src_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               en_d_q;

    logic [1:0] grant;
    logic       grant_id;
    logic       accept;

    // Gating with reset keeps ready low while reset is held, even in IDLE.
    rr_arb2 u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .enable_i     ((state_q == ST_IDLE) && reset),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    assign accept = |grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_SHIFT;
            ST_SHIFT:  if (idx_q == '0) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_REPORT;
            ST_REPORT: if (res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        det_clr    = (state_q == ST_CLEAR);
        det_en     = (state_q == ST_SHIFT);
        det_bit    = (state_q == ST_SHIFT) & frame_q[idx_q];
        res_valid  = (state_q == ST_REPORT);
        res_count  = cnt_q;
        res_src    = src_q;
    end

    // det_z lags det_en by one cycle, so hits are qualified with the delayed enable.
    always_comb begin
        frame_d      = frame_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        if (accept) begin
            frame_d      = grant_id ? req1_frame : req0_frame;
            src_d        = grant_id;
            last_grant_d = grant_id;
            cnt_d        = '0;
        end else if (en_d_q && det_z && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_CLEAR) begin
            idx_d = IDX_W'(FRAME_W - 1);
        end else if ((state_q == ST_SHIFT) && (idx_q != '0)) begin
            idx_d = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q      <= '0;
            src_q        <= SRC0;
            last_grant_q <= SRC1;
            cnt_q        <= '0;
            idx_q        <= '0;
            en_d_q       <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            en_d_q       <= det_en;
        end
    end

endmodule
